// File: rtl/dsp_out_fifo_pkg.sv
// dsp_out_fifo_pkg: shared DSP output-path sizing constants and helpers.
package dsp_out_fifo_pkg;
  function automatic int dsp_aw(input int depth);
    return $clog2(depth);
  endfunction
  localparam int DSP_DW = 32;
  localparam int DSP_DEPTH = 16;
  localparam int DSP_AW = dsp_aw(DSP_DEPTH);
  localparam int DSP_LW = DSP_AW + 1;
endpackage

// File: rtl/stereo_fifo_ram.sv
// stereo_fifo_ram: stereo-pair storage, synchronous write, asynchronous read, no reset.
module stereo_fifo_ram #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [2*DW-1:0]   wdata,
  input  logic [AW-1:0]     raddr,
  output logic [2*DW-1:0]   rdata
);
  logic [2*DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/dsp_out_fifo.sv
// dsp_out_fifo: FWFT stereo sample queue between the DSP output and the DAC consumer.
module dsp_out_fifo
  import dsp_out_fifo_pkg::*;
#(
  parameter int DW = DSP_DW,
  parameter int DEPTH = DSP_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_en,
  input  logic [DW-1:0]            ch1_din,
  input  logic [DW-1:0]            ch2_din,
  output logic                     full,
  input  logic                     read_en,
  output logic [DW-1:0]            ch1_dout,
  output logic [DW-1:0]            ch2_dout,
  output logic                     empty,
  input  logic                     flush,
  output logic [dsp_aw(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = dsp_aw(DEPTH);
  logic [AW:0] wptr, rptr;
  logic [2*DW-1:0] rd, hold;
  logic push, pop;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;
  assign push = write_en & ~full;
  assign pop = read_en & ~empty;
  stereo_fifo_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk(clk),
    .we(push & ~flush & ~rst),
    .waddr(wptr[AW-1:0]),
    .wdata({ch1_din, ch2_din}),
    .raddr(rptr[AW-1:0]),
    .rdata(rd)
  );
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (write_en && full) overflow <= 1'b1;
      if (read_en && empty) underflow <= 1'b1;
    end
  end
  // Last head seen keeps dout stable while the queue is empty.
  always_ff @(posedge clk)
    if (rst) hold <= '0;
    else if (!empty) hold <= rd;
  assign {ch1_dout, ch2_dout} = empty ? hold : rd;
endmodule

// File: tb/tb_dsp_out_fifo.sv
// tb_dsp_out_fifo: directed scoreboard bench for dsp_out_fifo.
module tb_dsp_out_fifo;
  import dsp_out_fifo_pkg::*;
  logic clk = 1'b0;
  logic rst, write_en, read_en, flush;
  logic [31:0] ch1_din, ch2_din, ch1_dout, ch2_dout;
  logic full, empty, overflow, underflow;
  logic [DSP_LW-1:0] level;
  logic [63:0] q[$];
  logic m_ovf, m_unf;
  int errors = 0;
  int checks = 0;

  dsp_out_fifo dut (
    .clk(clk), .rst(rst), .write_en(write_en), .ch1_din(ch1_din), .ch2_din(ch2_din),
    .full(full), .read_en(read_en), .ch1_dout(ch1_dout), .ch2_dout(ch2_dout),
    .empty(empty), .flush(flush), .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic fl, input logic we, input logic re,
                       input logic [31:0] d1, input logic [31:0] d2);
    logic full_m, empty_m;
    rst = r; flush = fl; write_en = we; read_en = re; ch1_din = d1; ch2_din = d2;
    full_m = q.size() == 16;
    empty_m = q.size() == 0;
    if (!r && !fl && re && !empty_m) chk("pop_data", {ch1_dout, ch2_dout}, q[0]);
    @(posedge clk);
    #1;
    if (r || fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (re && !empty_m) void'(q.pop_front());
      if (we && !full_m) q.push_back({d1, d2});
      if (we && full_m) m_ovf = 1'b1;
      if (re && empty_m) m_unf = 1'b1;
    end
    rst = 1'b0; flush = 1'b0; write_en = 1'b0; read_en = 1'b0;
    chk("level", 64'(level), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("full", 64'(full), 64'(q.size() == 16));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("underflow", 64'(underflow), 64'(m_unf));
    if (q.size() > 0) chk("head", {ch1_dout, ch2_dout}, q[0]);
  endtask

  initial begin
    m_ovf = 1'b0; m_unf = 1'b0;
    rst = 1'b1; flush = 1'b0; write_en = 1'b0; read_en = 1'b0; ch1_din = '0; ch2_din = '0;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("reset_dout", {ch1_dout, ch2_dout}, 64'h0);
    // fill to full
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0, 32'(i), ~32'(i));
    chk("full_after_16", 64'(full), 64'h1);
    chk("head_after_16", {ch1_dout, ch2_dout}, {32'h0, 32'hFFFF_FFFF});
    // push while full with pop: push dropped
    cycle(0, 0, 1, 1, 32'hDEAD_BEEF, 32'hBAD0_BAD0);
    chk("ovf_level", 64'(level), 64'd15);
    for (int i = 1; i < 16; i++) begin
      chk("pop_order", 64'(ch1_dout), 64'(i));
      cycle(0, 0, 0, 1, 0, 0);
    end
    // pop on empty with push
    cycle(0, 0, 1, 1, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    chk("unf_dout", {ch1_dout, ch2_dout}, {32'hA5A5_A5A5, 32'h5A5A_5A5A});
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    // steady state at level 3 with wrap
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 32'(100 + i), 32'(200 + i));
    for (int i = 3; i < 43; i++) begin
      chk("delay3", 64'(ch1_dout), 64'(100 + i - 3));
      cycle(0, 0, 1, 1, 32'(100 + i), 32'(200 + i));
    end
    // flush at level 7 with push and pop
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 32'(300 + i), 32'(400 + i));
    chk("level7", 64'(level), 64'd7);
    cycle(0, 1, 1, 1, 32'h1234_5678, 32'h8765_4321);
    cycle(0, 0, 1, 0, 32'h0000_0777, 32'h0000_0888);
    chk("flush_new_head", {ch1_dout, ch2_dout}, {32'h0000_0777, 32'h0000_0888});
    // mid-stream reset at level 5
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 32'(500 + i), 32'(600 + i));
    chk("level5", 64'(level), 64'd5);
    cycle(1, 0, 1, 1, 32'hFFFF_0000, 32'h0000_FFFF);
    chk("rst_dout", {ch1_dout, ch2_dout}, 64'h0);
    cycle(0, 0, 1, 0, 32'h0000_0AAA, 32'h0000_0BBB);
    cycle(0, 0, 1, 0, 32'h0000_0CCC, 32'h0000_0DDD);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
